fixed_to_fp: RTL

Converts the Monte-Carlo fixed-point format (sign, 1 integer bit, FRAC_W fractional bits) back to IEEE-754 single precision. It is the return path to the float domain after fixed-point accumulation.
Uses an iterative 5-step leading-zero normaliser (shift by 16/8/4/2/1) with valid/ready handshakes on both sides.
Conversion is exact; no rounding is required.

---
 rtl/fixed_to_fp.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fixed_to_fp.sv
// fixed_to_fp: converts a sign / 1 integer bit / FRAC_W fractional bit
// fixed-point value to IEEE-754 single precision. The leading-zero
// normaliser is iterative: one shift step of 16/8/4/2/1 per cycle, then
// the result is packed and held until the downstream handshake.
module fixed_to_fp #(
  parameter int FRAC_W   = 19,
  parameter int EXP_BIAS = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              sign_i,
  input  logic              integer_i,
  input  logic [FRAC_W-1:0] fractional_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       fp_o
);

  localparam int unsigned MW        = FRAC_W + 1;
  localparam logic [7:0]  EXP_BIAS8 = 8'(EXP_BIAS);

  typedef enum logic [2:0] {IDLE, S16, S8, S4, S2, S1, HOLD} state_t;

  state_t          state_q;
  logic [MW-1:0]   m_q;
  logic [MW-1:0]   m_d;
  logic [4:0]      k_q;
  logic [4:0]      k_d;
  logic            sign_q;
  logic            out_valid_q;
  logic [31:0]     fp_q;
  int unsigned     shift_n;
  logic [7:0]      exp_w;
  logic [22:0]     mant_w;

  // True when the top n bits of m are all zero; stages wider than m never shift.
  function automatic logic top_zero(input logic [MW-1:0] m, input int unsigned n);
    logic z;
    z = (n <= MW);
    for (int unsigned i = 0; i < MW; i++) begin
      if ((i + n >= MW) && m[i]) z = 1'b0;
    end
    return z;
  endfunction

  // One normalisation step for the current state (shift amount from state).
  always_comb begin
    shift_n = 0;
    case (state_q)
      S16:     shift_n = 16;
      S8:      shift_n = 8;
      S4:      shift_n = 4;
      S2:      shift_n = 2;
      S1:      shift_n = 1;
      default: shift_n = 0;
    endcase
    m_d = m_q;
    k_d = k_q;
    if ((shift_n != 0) && top_zero(m_q, shift_n)) begin
      m_d = m_q << shift_n;
      k_d = k_q + 5'(shift_n);
    end
  end

  // Exponent and left-aligned mantissa from the fully normalised magnitude.
  always_comb begin
    exp_w                 = EXP_BIAS8 - {3'b000, k_d};
    mant_w                = '0;
    mant_w[22 -: FRAC_W]  = m_d[FRAC_W-1:0];
  end

  // Control FSM with registered result and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      k_q         <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      fp_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            m_q     <= {integer_i, fractional_i};
            sign_q  <= sign_i;
            k_q     <= '0;
            state_q <= S16;
          end
        end
        S16: begin m_q <= m_d; k_q <= k_d; state_q <= S8; end
        S8:  begin m_q <= m_d; k_q <= k_d; state_q <= S4; end
        S4:  begin m_q <= m_d; k_q <= k_d; state_q <= S2; end
        S2:  begin m_q <= m_d; k_q <= k_d; state_q <= S1; end
        S1: begin
          m_q         <= m_d;
          k_q         <= k_d;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
          if (m_d == '0) fp_q <= {sign_q, 31'b0};
          else           fp_q <= {sign_q, exp_w, mant_w};
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = out_valid_q;
  assign fp_o        = fp_q;

endmodule
